nrisc_int_ctrl: RTL and testbench

Interrupt controller for the NRISC core. It collects 8 external request lines and latches them as pending, then masks and prioritises them. It presents one channel at a time to the core's INTERRUPT_ch/INTERRUPT_flag inputs and sequences the acknowledge and end-of-interrupt handshake. Configuration uses a small memory-mapped register window driven from the core's data-memory strobes.

---
 rtl/nrisc_int_ctrl_pkg.sv | 27 ++
 rtl/nrisc_int_ctrl_if.sv | 26 ++
 rtl/nrisc_int_ctrl_prio.sv | 21 ++
 rtl/nrisc_int_ctrl.sv | 124 ++++++++++++
 tb/tb_nrisc_int_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nrisc_int_ctrl_pkg.sv
// Shared constants, register map and FSM encoding for the NRISC interrupt controller.
// Optional build macro used by the top: NRISC_INT_LEVEL_EN.
package nrisc_int_ctrl_pkg;

    localparam int TAM  = 16;
    localparam int N_CH = 8;
    localparam int CH_W = 3;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_TRIG = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [N_CH-1:0] v;
        v     = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/nrisc_int_ctrl_if.sv
// Core-side bus of the interrupt controller: register window plus the
// request/acknowledge/end-of-interrupt handshake.
interface nrisc_int_ctrl_if;
    import nrisc_int_ctrl_pkg::*;

    logic [1:0]     reg_addr;
    logic [TAM-1:0] reg_wdata;
    logic           reg_write;
    logic           reg_load;
    logic [TAM-1:0] reg_rdata;
    logic [7:0]     int_ch;
    logic           int_flag;
    logic           int_ack;
    logic           int_eoi;

    modport master (
        output reg_addr, reg_wdata, reg_write, reg_load, int_ack, int_eoi,
        input  reg_rdata, int_ch, int_flag
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_write, reg_load, int_ack, int_eoi,
        output reg_rdata, int_ch, int_flag
    );

endinterface

// File: rtl/nrisc_int_ctrl_prio.sv
// Fixed-priority encoder: reports the lowest set request index and whether
// any request is set.
module nrisc_int_prio
    import nrisc_int_ctrl_pkg::*;
(
    input  logic [N_CH-1:0] req,
    output logic [CH_W-1:0] idx,
    output logic            valid
);

    // Scan high to low so the last hit, the lowest index, wins.
    always_comb begin
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) idx = CH_W'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/nrisc_int_ctrl.sv
// NRISC interrupt controller: synchronise and edge-detect requests, latch pending,
// mask, prioritise and run the ack/EOI handshake. NRISC_INT_LEVEL_EN adds TRIG.
module nrisc_int_ctrl
    import nrisc_int_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] irq_in,
    nrisc_int_ctrl_if.slave bus
);

    logic [N_CH-1:0] sync1_reg, sync2_reg, prev_reg;
    logic [N_CH-1:0] mask_reg, pend_reg, pend_next;
    logic [N_CH-1:0] trig, edge_det, pend_set, pend_clr, w1c, ack_clr;
    logic [CH_W-1:0] ch_reg, winner;
    logic            any_eligible, ack_take, withdraw, busy, flag;
    logic            wr_mask, wr_pend;
    logic [TAM-1:0]  rdata_reg, rdata_next;
    state_t          state_reg, state_next;
    logic            unused_wdata;

    assign wr_mask      = bus.reg_write && (bus.reg_addr == REG_MASK);
    assign wr_pend      = bus.reg_write && (bus.reg_addr == REG_PEND);
    assign unused_wdata = ^bus.reg_wdata[TAM-1:N_CH];

`ifdef NRISC_INT_LEVEL_EN
    logic [N_CH-1:0] trig_reg;
    logic            wr_trig;

    assign wr_trig = bus.reg_write && (bus.reg_addr == REG_TRIG);

    always_ff @(posedge clk) begin
        if (rst)          trig_reg <= '0;
        else if (wr_trig) trig_reg <= bus.reg_wdata[N_CH-1:0];
    end

    assign trig = trig_reg;
`else
    assign trig = '0;
`endif

    assign edge_det = sync2_reg & ~prev_reg;
    assign withdraw = (state_reg == REQ) && !mask_reg[ch_reg];
    assign ack_take = (state_reg == REQ) && mask_reg[ch_reg] && bus.int_ack;
    assign ack_clr  = ack_take ? ch_onehot(ch_reg) : '0;
    assign w1c      = wr_pend ? bus.reg_wdata[N_CH-1:0] : '0;

    // Set beats clear, so a fresh edge or a held level survives W1C and ack.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_pend
            assign pend_set[gi]  = edge_det[gi] | (trig[gi] & sync2_reg[gi]);
            assign pend_clr[gi]  = w1c[gi] | ack_clr[gi];
            assign pend_next[gi] = pend_set[gi] | (pend_reg[gi] & ~pend_clr[gi]);
        end
    endgenerate

    nrisc_int_prio u_prio (
        .req   (pend_reg & mask_reg),
        .idx   (winner),
        .valid (any_eligible)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_eligible) state_next = REQ;
            REQ: begin
                if (withdraw)         state_next = IDLE;
                else if (bus.int_ack) state_next = SERVICE;
            end
            SERVICE: if (bus.int_eoi) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        flag = (state_reg == REQ);
        busy = (state_reg != IDLE);
    end

    always_comb begin
        rdata_next = '0;
        case (bus.reg_addr)
            REG_MASK: rdata_next[N_CH-1:0] = mask_reg;
            REG_PEND: rdata_next[N_CH-1:0] = pend_reg;
            REG_STAT: begin
                rdata_next[0]        = busy;
                rdata_next[1]        = flag;
                rdata_next[8+:CH_W]  = ch_reg;
            end
            default:  rdata_next[N_CH-1:0] = trig;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
            pend_reg  <= '0;
            mask_reg  <= '0;
            ch_reg    <= '0;
            rdata_reg <= '0;
        end else begin
            sync1_reg <= irq_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            pend_reg  <= pend_next;
            if (wr_mask)                          mask_reg  <= bus.reg_wdata[N_CH-1:0];
            if ((state_reg == IDLE) && any_eligible) ch_reg <= winner;
            if (bus.reg_load)                     rdata_reg <= rdata_next;
        end
    end

    assign bus.int_flag  = flag;
    assign bus.int_ch    = {{(8-CH_W){1'b0}}, ch_reg};
    assign bus.reg_rdata = rdata_reg;

endmodule

// File: tb/tb_nrisc_int_ctrl.sv
// Self-checking bench for nrisc_int_ctrl: scoreboard queues hold expected read
// data and granted channels, popped when the DUT produces them.
module tb_nrisc_int_ctrl;
    import nrisc_int_ctrl_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] irq_in;

    nrisc_int_ctrl_if bus ();

    nrisc_int_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int             errors = 0;
    int             checks = 0;
    logic [TAM-1:0] exp_q[$];
    int             ch_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [TAM-1:0] d);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_write = 1'b1;
        tick();
        bus.reg_write = 1'b0;
        $display("write addr=%0d data=%h", a, d);
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [TAM-1:0] d);
        bus.reg_addr = a;
        bus.reg_load = 1'b1;
        tick();
        bus.reg_load = 1'b0;
        d = bus.reg_rdata;
        $display("read  addr=%0d data=%h", a, d);
    endtask

    task automatic pulse_irq(input logic [N_CH-1:0] m);
        irq_in = irq_in | m;
        tick();
        irq_in = irq_in & ~m;
    endtask

    task automatic pulse_ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
    endtask

    task automatic wait_flag(output int n);
        n = 0;
        while (!bus.int_flag && n < 20) begin
            tick();
            n++;
        end
        if (!bus.int_flag) n = -1;
        $display("grant flag=%0b ch=%0d after %0d cycles", bus.int_flag, bus.int_ch, n);
    endtask

    task automatic test_reset();
        logic [TAM-1:0] rd, e;
        rst = 1'b1;
        irq_in = '0;
        bus.reg_addr = '0; bus.reg_wdata = '0; bus.reg_write = 0;
        bus.reg_load = 0;  bus.int_ack = 0;    bus.int_eoi = 0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (bus.int_flag !== 1'b0 || bus.int_ch !== 8'h00 || bus.reg_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: flag=%b ch=%h rdata=%h required 0/00/0000",
                     bus.int_flag, bus.int_ch, bus.reg_rdata);
        end
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back(16'h0000);
            reg_rd(2'(a), rd);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin errors++; $display("FAIL reset_reg%0d: got %h required %h", a, rd, e); end
        end
    endtask

    task automatic test_regs();
        logic [TAM-1:0] rd, e;
        reg_wr(REG_MASK, 16'hFFFF);
        exp_q.push_back(16'h00FF);
        reg_rd(REG_MASK, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL mask_upper_zero: got %h required %h", rd, e); end
        reg_wr(REG_MASK, 16'h005A);
        // Simultaneous write and read returns the old value.
        exp_q.push_back(16'h005A);
        bus.reg_addr = REG_MASK; bus.reg_wdata = 16'h00A5;
        bus.reg_write = 1'b1; bus.reg_load = 1'b1;
        tick();
        bus.reg_write = 1'b0; bus.reg_load = 1'b0;
        rd = bus.reg_rdata; e = exp_q.pop_front(); checks++;
        $display("read+write addr=0 data=%h", rd);
        if (rd !== e) begin errors++; $display("FAIL wr_rd_same_cycle: got %h required %h", rd, e); end
        exp_q.push_back(16'h00A5);
        reg_rd(REG_MASK, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL mask_after_write: got %h required %h", rd, e); end
        bus.reg_addr = REG_PEND;
        tick(); tick(); tick();
        checks++;
        if (bus.reg_rdata !== 16'h00A5) begin
            errors++; $display("FAIL rdata_hold: got %h required 00a5", bus.reg_rdata);
        end
    endtask

    task automatic test_basic();
        logic [TAM-1:0] rd, e;
        int ec;
        reg_wr(REG_MASK, 16'h00FF);
        ch_q.push_back(5);
        pulse_irq(8'h20);
        tick(); tick();
        checks++;
        if (bus.int_flag !== 1'b0) begin errors++; $display("FAIL latency_early: flag=%b required 0", bus.int_flag); end
        tick();
        ec = ch_q.pop_front(); checks++;
        if (bus.int_flag !== 1'b1 || bus.int_ch !== 8'(ec)) begin
            errors++; $display("FAIL grant_ch5: flag=%b ch=%0d required 1/%0d", bus.int_flag, bus.int_ch, ec);
        end
        pulse_ack();
        checks++;
        if (bus.int_flag !== 1'b0) begin errors++; $display("FAIL ack_drop: flag=%b required 0", bus.int_flag); end
        exp_q.push_back(16'h0000);
        reg_rd(REG_PEND, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL pend_after_ack: got %h required %h", rd, e); end
        exp_q.push_back(16'h0501);
        reg_rd(REG_STAT, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL stat_service: got %h required %h", rd, e); end
        pulse_eoi();
        exp_q.push_back(16'h0500);
        reg_rd(REG_STAT, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL stat_after_eoi: got %h required %h", rd, e); end
    endtask

    task automatic test_masked();
        logic [TAM-1:0] rd, e;
        int n, ec;
        reg_wr(REG_MASK, 16'h0000);
        pulse_irq(8'h04);
        tick(); tick(); tick(); tick();
        checks++;
        if (bus.int_flag !== 1'b0) begin errors++; $display("FAIL masked_no_flag: flag=%b required 0", bus.int_flag); end
        pulse_ack();
        exp_q.push_back(16'h0004);
        reg_rd(REG_PEND, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL pend_masked: got %h required %h", rd, e); end
        ch_q.push_back(2);
        reg_wr(REG_MASK, 16'h0004);
        wait_flag(n);
        ec = ch_q.pop_front(); checks++;
        if (n !== 1 || bus.int_ch !== 8'(ec)) begin
            errors++; $display("FAIL unmask_grant: cycles=%0d ch=%0d required 1/%0d", n, bus.int_ch, ec);
        end
        pulse_ack(); pulse_eoi();
        reg_wr(REG_MASK, 16'h00FF);
    endtask

    task automatic test_priority();
        int n, ec;
        ch_q.push_back(1); ch_q.push_back(6);
        pulse_irq(8'h42);
        wait_flag(n);
        ec = ch_q.pop_front(); checks++;
        if (n !== 3 || bus.int_ch !== 8'(ec)) begin
            errors++; $display("FAIL prio_first: cycles=%0d ch=%0d required 3/%0d", n, bus.int_ch, ec);
        end
        pulse_ack(); pulse_eoi();
        wait_flag(n);
        ec = ch_q.pop_front(); checks++;
        if (n !== 1 || bus.int_ch !== 8'(ec)) begin
            errors++; $display("FAIL prio_second: cycles=%0d ch=%0d required 1/%0d", n, bus.int_ch, ec);
        end
        ch_q.push_back(0);
        pulse_irq(8'h01);
        tick(); tick(); tick(); tick();
        checks++;
        if (bus.int_flag !== 1'b1 || bus.int_ch !== 8'd6) begin
            errors++; $display("FAIL req_hold: flag=%b ch=%0d required 1/6", bus.int_flag, bus.int_ch);
        end
        pulse_ack(); pulse_eoi();
        wait_flag(n);
        ec = ch_q.pop_front(); checks++;
        if (n !== 1 || bus.int_ch !== 8'(ec)) begin
            errors++; $display("FAIL prio_third: cycles=%0d ch=%0d required 1/%0d", n, bus.int_ch, ec);
        end
        pulse_ack(); pulse_eoi();
    endtask

    task automatic test_withdraw();
        logic [TAM-1:0] rd, e;
        int n, ec;
        ch_q.push_back(3);
        pulse_irq(8'h08);
        wait_flag(n);
        ec = ch_q.pop_front(); checks++;
        if (bus.int_flag !== 1'b1 || bus.int_ch !== 8'(ec)) begin
            errors++; $display("FAIL withdraw_grant: flag=%b ch=%0d required 1/%0d", bus.int_flag, bus.int_ch, ec);
        end
        reg_wr(REG_MASK, 16'h00F7);
        tick();
        checks++;
        if (bus.int_flag !== 1'b0) begin errors++; $display("FAIL withdraw_drop: flag=%b required 0", bus.int_flag); end
        exp_q.push_back(16'h0300);
        reg_rd(REG_STAT, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL withdraw_stat: got %h required %h", rd, e); end
        exp_q.push_back(16'h0008);
        reg_rd(REG_PEND, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL withdraw_pend: got %h required %h", rd, e); end
        reg_wr(REG_PEND, 16'h0008);
        exp_q.push_back(16'h0000);
        reg_rd(REG_PEND, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL w1c_clear: got %h required %h", rd, e); end
    endtask

    task automatic test_collision_and_reset();
        logic [TAM-1:0] rd, e;
        int n, ec;
        reg_wr(REG_MASK, 16'h0000);
        pulse_irq(8'h10); tick(); tick();
        pulse_irq(8'h10); tick();
        reg_wr(REG_PEND, 16'h0010);
        exp_q.push_back(16'h0010);
        reg_rd(REG_PEND, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL set_beats_w1c: got %h required %h", rd, e); end
        ch_q.push_back(4);
        reg_wr(REG_MASK, 16'h0010);
        wait_flag(n);
        ec = ch_q.pop_front(); checks++;
        if (n !== 1 || bus.int_ch !== 8'(ec)) begin
            errors++; $display("FAIL grant_ch4: cycles=%0d ch=%0d required 1/%0d", n, bus.int_ch, ec);
        end
        pulse_ack();
        exp_q.push_back(16'h0401);
        reg_rd(REG_STAT, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL stat_service_ch4: got %h required %h", rd, e); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (bus.int_flag !== 1'b0 || bus.int_ch !== 8'h00) begin
            errors++; $display("FAIL rst_mid: flag=%b ch=%h required 0/00", bus.int_flag, bus.int_ch);
        end
        for (int a = 0; a < 3; a++) begin
            exp_q.push_back(16'h0000);
            reg_rd(2'(a), rd); e = exp_q.pop_front(); checks++;
            if (rd !== e) begin errors++; $display("FAIL rst_mid_reg%0d: got %h required %h", a, rd, e); end
        end
    endtask

    task automatic test_trig();
        logic [TAM-1:0] rd, e;
`ifdef NRISC_INT_LEVEL_EN
        int n, ec;
        reg_wr(REG_TRIG, 16'h0001);
        exp_q.push_back(16'h0001);
        reg_rd(REG_TRIG, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL trig_rw: got %h required %h", rd, e); end
        reg_wr(REG_MASK, 16'h0001);
        ch_q.push_back(0); ch_q.push_back(0);
        irq_in = 8'h01;
        wait_flag(n);
        ec = ch_q.pop_front(); checks++;
        if (bus.int_flag !== 1'b1 || bus.int_ch !== 8'(ec)) begin
            errors++; $display("FAIL level_grant: flag=%b ch=%0d required 1/%0d", bus.int_flag, bus.int_ch, ec);
        end
        pulse_ack(); pulse_eoi();
        wait_flag(n);
        ec = ch_q.pop_front(); checks++;
        if (n !== 1 || bus.int_ch !== 8'(ec)) begin
            errors++; $display("FAIL level_rerequest: cycles=%0d ch=%0d required 1/%0d", n, bus.int_ch, ec);
        end
        irq_in = '0;
        rst = 1'b1; tick(); rst = 1'b0;
`else
        reg_wr(REG_TRIG, 16'h00FF);
        exp_q.push_back(16'h0000);
        reg_rd(REG_TRIG, rd); e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL trig_disabled: got %h required %h", rd, e); end
`endif
    endtask

    initial begin
        test_reset();
        test_regs();
        test_basic();
        test_masked();
        test_priority();
        test_withdraw();
        test_collision_and_reset();
        test_trig();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
